// File: rtl/hmac_stream_arbiter.sv
// hmac_stream_arbiter
//   Merges two AXI-Stream requesters into the shared add_metadata/hmac
//   pipeline. Arbitration is per packet: a port keeps the grant until its
//   tlast beat is accepted. Contention alternates, with port 0 winning the
//   first contention after reset. Accepted beats go through a 2-entry skid
//   buffer. Each buffered beat carries its source port, shown on m_axis_tsrc.
//
// Ports
//   aclk, areset              clock, synchronous active-high reset
//   s0_axis_*  / s1_axis_*    requester streams (tready is an output)
//   m_axis_*                  merged stream (tready is an input)
//   m_axis_tsrc               source port of the beat on m_axis
//   en0, en1                  per-port arbitration enable (sampled in IDLE)
//   pkt_cnt0, pkt_cnt1        packets accepted per port, wrapping
module hmac_stream_arbiter #(
  parameter int DATA_WIDTH = 512,
  parameter int TID_WIDTH  = 6
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    s0_axis_tvalid,
  output logic                    s0_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s0_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axis_tkeep,
  input  logic [TID_WIDTH-1:0]    s0_axis_tid,
  input  logic                    s0_axis_tlast,
  input  logic                    s1_axis_tvalid,
  output logic                    s1_axis_tready,
  input  logic [DATA_WIDTH-1:0]   s1_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s1_axis_tkeep,
  input  logic [TID_WIDTH-1:0]    s1_axis_tid,
  input  logic                    s1_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [TID_WIDTH-1:0]    m_axis_tid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tsrc,
  input  logic                    en0,
  input  logic                    en1,
  output logic [31:0]             pkt_cnt0,
  output logic [31:0]             pkt_cnt1
);
  localparam int KEEP_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {S_IDLE, S_GRANT0, S_GRANT1} state_t;

  typedef struct packed {
    logic                  src;
    logic                  last;
    logic [TID_WIDTH-1:0]  tid;
    logic [KEEP_W-1:0]     keep;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  state_t      r_state, w_state_nxt;
  logic        r_last_grant;
  beat_t       r_buf [2];
  logic        r_wptr, r_rptr;
  logic [1:0]  r_count;
  logic [31:0] r_pkt_cnt0, r_pkt_cnt1;

  logic  w_req0, w_req1, w_full, w_sel1, w_in_valid, w_in_last;
  logic  w_push, w_pop;
  beat_t w_in_beat, w_head;

  assign w_full     = (r_count == 2'd2);
  assign w_sel1     = (r_state == S_GRANT1);
  assign w_in_valid = ((r_state == S_GRANT0) && s0_axis_tvalid) ||
                      ((r_state == S_GRANT1) && s1_axis_tvalid);
  assign w_in_last  = w_sel1 ? s1_axis_tlast : s0_axis_tlast;
  assign w_push     = w_in_valid && !w_full;
  assign w_pop      = (r_count != 2'd0) && m_axis_tready;

  // Enables only qualify requests in IDLE; a granted packet always completes.
  assign w_req0 = s0_axis_tvalid && en0;
  assign w_req1 = s1_axis_tvalid && en1;

  assign s0_axis_tready = (r_state == S_GRANT0) && !w_full;
  assign s1_axis_tready = (r_state == S_GRANT1) && !w_full;

  assign w_in_beat = w_sel1 ?
    '{src: 1'b1, last: s1_axis_tlast, tid: s1_axis_tid, keep: s1_axis_tkeep, data: s1_axis_tdata} :
    '{src: 1'b0, last: s0_axis_tlast, tid: s0_axis_tid, keep: s0_axis_tkeep, data: s0_axis_tdata};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req0 && w_req1) w_state_nxt = r_last_grant ? S_GRANT0 : S_GRANT1;
        else if (w_req0)      w_state_nxt = S_GRANT0;
        else if (w_req1)      w_state_nxt = S_GRANT1;
      end
      // Returning to IDLE after every packet gives the one-cycle bubble.
      S_GRANT0, S_GRANT1: if (w_push && w_in_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_state_nxt == S_GRANT0) r_last_grant <= 1'b0;
      if (r_state == S_IDLE && w_state_nxt == S_GRANT1) r_last_grant <= 1'b1;
    end
  end

  // Skid buffer pointers. tready is based on the registered fill level, so a
  // beat can always land in the spare entry. With one entry occupied and the
  // sink ready, a beat is pushed and popped every cycle.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; r_count gates everything read from it.
  always_ff @(posedge aclk) begin
    if (w_push) r_buf[r_wptr] <= w_in_beat;
  end

  assign w_head        = r_buf[r_rptr];
  assign m_axis_tvalid = (r_count != 2'd0);
  assign m_axis_tdata  = w_head.data;
  assign m_axis_tkeep  = w_head.keep;
  assign m_axis_tid    = w_head.tid;
  assign m_axis_tlast  = w_head.last;
  assign m_axis_tsrc   = m_axis_tvalid && w_head.src;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pkt_cnt0 <= 32'd0;
      r_pkt_cnt1 <= 32'd0;
    end else begin
      if (w_push && w_in_last && !w_sel1) r_pkt_cnt0 <= r_pkt_cnt0 + 32'd1;
      if (w_push && w_in_last &&  w_sel1) r_pkt_cnt1 <= r_pkt_cnt1 + 32'd1;
    end
  end

  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;

endmodule

// File: doc/hmac_stream_arbiter.md
HMAC_STREAM_ARBITER -- requirements
Module: hmac_stream_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 512, meaning tdata width; tkeep width is DATA_WIDTH/8.
REQ-002 SHALL have parameter TID_WIDTH, default 6, meaning tid width.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 areset  in  1  synchronous reset, active-high.
REQ-006 s0_axis_tvalid/tready/tdata/tkeep/tid/tlast  in (tready out)  1/1/DATA_WIDTH/DATA_WIDTH/8/TID_WIDTH/1  requester 0 stream.
REQ-007 s1_axis_tvalid/tready/tdata/tkeep/tid/tlast  in (tready out)  same widths  requester 1 stream.
REQ-008 m_axis_tvalid/tready/tdata/tkeep/tid/tlast  out (tready in)  same widths  merged stream into the shared add_metadata/hmac pipeline.
REQ-009 m_axis_tsrc  out  1  source port of the current output beat.
REQ-010 en0, en1  in  1  per-port arbitration enable.
REQ-011 pkt_cnt0, pkt_cnt1  out  32  packets forwarded per port.

Function
REQ-012 SHALL arbitrate at packet granularity; once granted, a port keeps the grant until its tlast beat is accepted on its s-side.
REQ-013 FSM states: IDLE, GRANT0, GRANT1.
REQ-014 IDLE: request r_i = s_i_tvalid & en_i; no request -> stay IDLE; one request -> GRANT of that port; both -> grant the port not equal to last_grant.
REQ-015 last_grant SHALL update on entry to GRANTx; reset value 1, so port 0 wins first contention.
REQ-016 GRANTx -> IDLE on cycle where s_x tvalid & tready & tlast; one-cycle IDLE bubble between packets is required.
REQ-017 en_i SHALL be sampled only in IDLE; deasserting en_x during GRANTx SHALL NOT truncate or abort the packet.
REQ-018 Non-granted port tready SHALL be 0; in IDLE both treadys SHALL be 0.
REQ-019 Output SHALL pass through a 2-entry skid buffer; granted tready = buffer not full; beat accepted at cycle t appears on m_axis no earlier than t+1.
REQ-020 Full throughput: with m_axis_tready held 1, one beat per cycle sustained within a packet.
REQ-021 tdata/tkeep/tid/tlast SHALL pass unmodified; m_axis_tsrc = granted port index stored per beat.
REQ-022 m_axis payload SHALL remain stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 Buffer full and m_axis_tready=0: granted tready=0, no beat loss or duplication.
REQ-024 pkt_cnt_i SHALL increment by 1 when port i's tlast beat is accepted on the s-side; wraps 0xFFFFFFFF -> 0.
REQ-025 Packets from one port SHALL emerge in input order; beats of two packets never interleave.

Reset
REQ-026 On areset=1: state IDLE, last_grant=1, buffer empty, m_axis_tvalid=0, m_axis_tsrc=0, s0/s1 tready=0, pkt_cnt0=pkt_cnt1=0.
REQ-027 Reset mid-packet SHALL discard buffered beats; no partial packet is emitted after reset release.
REQ-028 First grant no earlier than the cycle after areset deasserts.

Verification
REQ-029 Both ports present 4-beat packets simultaneously after reset, m_axis_tready=1 -> port 0 packet (tsrc=0) then port 1 packet (tsrc=1), no interleaving, pkt_cnt0=pkt_cnt1=1.
REQ-030 Port 0 only, three back-to-back 2-beat packets -> three packets out, one IDLE bubble between each, pkt_cnt0=3.
REQ-031 Random m_axis_tready backpressure (50%) on 16-beat packets from both ports -> data/keep/tid/tlast match per-port scoreboard, payload stable while stalled.
REQ-032 en1=0, both requesting -> only port 0 served, s1_axis_tready stays 0; set en1=1 -> port 1 granted at next IDLE.
REQ-033 en0 deasserted at beat 2 of 4-beat port 0 packet -> full packet forwarded, then grant moves to port 1.
REQ-034 Force pkt_cnt0 to 0xFFFFFFFF via preloaded packets, send one more -> pkt_cnt0=0; areset mid-packet -> outputs at REQ-026 values next cycle.
